// File: rtl/scram_pkg.sv
// Shared constants, FSM encoding and 8-step LFSR advance for the 8-bit
// PCIe Gen1/Gen2 scrambler and descrambler (x^16+x^5+x^4+x^3+1, Galois form).
package scram_pkg;

  localparam logic [15:0] LFSR_INIT = 16'hFFFF;
  localparam logic [7:0]  COM_SYM   = 8'hBC;
  localparam logic [7:0]  SKP_SYM   = 8'h1C;
  // Bits toggled by the feedback bit after the shift: 0 (wrap), 3, 4, 5.
  localparam logic [15:0] TAP_MASK  = 16'h0039;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } scram_state_t;

  function automatic logic [15:0] lfsr_adv8(input logic [15:0] cur);
    logic [15:0] l;
    logic        fb;
    l = cur;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = l[15];
      l  = {l[14:0], 1'b0} ^ (fb ? TAP_MASK : 16'h0000);
    end
    return l;
  endfunction

endpackage

// File: rtl/scram_lfsr16.sv
// 16-bit scrambler LFSR: synchronous seed load, enable-gated 8-step advance,
// and the bit-reversed upper byte presented as the per-symbol key.
module scram_lfsr16
  import scram_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_INIT
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       load,
  input  logic       adv,
  output logic [7:0] key
);

  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (rstb) begin
      lfsr <= SEED;
    end else if (load) begin
      lfsr <= SEED;
    end else if (adv) begin
      lfsr <= lfsr_adv8(lfsr);
    end
  end

  always_comb begin
    key = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      key[i] = lfsr[15 - i];
    end
  end

endmodule

// File: rtl/descrambler_8bits.sv
// Receive-side descrambler: one decoded symbol per valid cycle, COM resync,
// SKP hold, lock tracking; one-cycle registered latency.
module descrambler_8bits
  import scram_pkg::*;
(
  input  logic       clk,
  input  logic       rstb,
  input  logic       valid_in,
  input  logic [7:0] data_in,
  input  logic       k_in,
  input  logic       rx_err,
  input  logic       disab_scram,
  output logic       valid_out,
  output logic [7:0] data_out,
  output logic       k_out,
  output logic       locked
);

  scram_state_t state, state_next;
  logic [7:0]   key;
  logic [7:0]   data_next;
  logic         lfsr_load;
  logic         lfsr_adv;

  scram_lfsr16 #(.SEED(LFSR_INIT)) u_lfsr (
    .clk  (clk),
    .rstb (rstb),
    .load (lfsr_load),
    .adv  (lfsr_adv),
    .key  (key)
  );

  // Symbol classification; the first matching rule wins, with rx_err first.
  always_comb begin
    state_next = state;
    data_next  = data_in;
    lfsr_load  = 1'b0;
    lfsr_adv   = 1'b0;
    if (valid_in) begin
      if (rx_err) begin
        lfsr_load  = 1'b1;
        state_next = HUNT;
      end else if (k_in && data_in == COM_SYM) begin
        lfsr_load  = 1'b1;
        state_next = LOCKED;
      end else if (k_in && data_in == SKP_SYM) begin
        lfsr_adv = 1'b0;
      end else if (k_in) begin
        lfsr_adv = (state == LOCKED);
      end else begin
        lfsr_adv = (state == LOCKED);
        if (state == LOCKED && !disab_scram) begin
          data_next = data_in ^ key;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      state     <= HUNT;
      valid_out <= 1'b0;
      data_out  <= '0;
      k_out     <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        state    <= state_next;
        data_out <= data_next;
        k_out    <= k_in;
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_descrambler_8bits.sv
// Directed bench for descrambler_8bits with hand-computed expected outputs.
module tb_descrambler_8bits;

  logic       clk = 1'b0;
  logic       rstb;
  logic       valid_in;
  logic [7:0] data_in;
  logic       k_in;
  logic       rx_err;
  logic       disab_scram;
  logic       valid_out;
  logic [7:0] data_out;
  logic       k_out;
  logic       locked;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  descrambler_8bits dut (
    .clk         (clk),
    .rstb        (rstb),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .k_in        (k_in),
    .rx_err      (rx_err),
    .disab_scram (disab_scram),
    .valid_out   (valid_out),
    .data_out    (data_out),
    .k_out       (k_out),
    .locked      (locked)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [7:0] d,
                            input logic k, input logic l);
    chk({tag, ".valid"},  {7'd0, valid_out}, {7'd0, v});
    chk({tag, ".data"},   data_out, d);
    chk({tag, ".k"},      {7'd0, k_out}, {7'd0, k});
    chk({tag, ".locked"}, {7'd0, locked}, {7'd0, l});
  endtask

  // Present one valid symbol, then sample #1 after the capturing edge.
  task automatic send(input logic [7:0] d, input logic k, input logic err, input logic dis);
    valid_in    = 1'b1;
    data_in     = d;
    k_in        = k;
    rx_err      = err;
    disab_scram = dis;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    data_in  = 8'hA5;
    k_in     = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rstb = 1'b1; valid_in = 1'b0; data_in = '0; k_in = 1'b0;
    rx_err = 1'b0; disab_scram = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 1'b0, 8'h00, 1'b0, 1'b0);
    rstb = 1'b0;

    // Basic lock and first three keys
    send(8'hBC, 1, 0, 0); expect_out("com1",  1, 8'hBC, 1, 1);
    send(8'h00, 0, 0, 0); expect_out("d1_0",  1, 8'hFF, 0, 1);
    send(8'h00, 0, 0, 0); expect_out("d1_1",  1, 8'h17, 0, 1);
    send(8'h00, 0, 0, 0); expect_out("d1_2",  1, 8'hC0, 0, 1);

    // SKP holds the LFSR
    send(8'hBC, 1, 0, 0); expect_out("com2",  1, 8'hBC, 1, 1);
    send(8'h1C, 1, 0, 0); expect_out("skp_a", 1, 8'h1C, 1, 1);
    send(8'h1C, 1, 0, 0); expect_out("skp_b", 1, 8'h1C, 1, 1);
    send(8'h00, 0, 0, 0); expect_out("d2_0",  1, 8'hFF, 0, 1);
    send(8'h00, 0, 0, 0); expect_out("d2_1",  1, 8'h17, 0, 1);

    // Other K symbol advances the LFSR
    send(8'hBC, 1, 0, 0); expect_out("com3",  1, 8'hBC, 1, 1);
    send(8'hFB, 1, 0, 0); expect_out("stp",   1, 8'hFB, 1, 1);
    send(8'h00, 0, 0, 0); expect_out("d3_0",  1, 8'h17, 0, 1);

    // disab_scram toggling with valid gaps
    send(8'hBC, 1, 0, 0); expect_out("com4",  1, 8'hBC, 1, 1);
    idle(3);              expect_out("gap0",  0, 8'hBC, 1, 1);
    send(8'h00, 0, 0, 1); expect_out("dis0",  1, 8'h00, 0, 1);
    idle(3);              expect_out("gap1",  0, 8'h00, 0, 1);
    send(8'h00, 0, 0, 1); expect_out("dis1",  1, 8'h00, 0, 1);
    idle(3);              expect_out("gap2",  0, 8'h00, 0, 1);
    send(8'h00, 0, 0, 0); expect_out("en2",   1, 8'hC0, 0, 1);

    // rx_err drops lock; data then passes unmodified
    send(8'h00, 0, 1, 0); expect_out("err",   1, 8'h00, 0, 0);
    send(8'h55, 0, 0, 0); expect_out("hunt",  1, 8'h55, 0, 0);
    send(8'hBC, 1, 0, 0); expect_out("com5",  1, 8'hBC, 1, 1);
    send(8'h00, 0, 0, 0); expect_out("d5_0",  1, 8'hFF, 0, 1);

    // COM carrying rx_err must not lock
    send(8'hBC, 1, 1, 0); expect_out("comerr", 1, 8'hBC, 1, 0);
    send(8'h00, 0, 0, 0); expect_out("d6_0",   1, 8'h00, 0, 0);

    // Reset mid-stream with a valid symbol present
    send(8'hBC, 1, 0, 0); expect_out("com7",  1, 8'hBC, 1, 1);
    send(8'h00, 0, 0, 0); expect_out("d7_0",  1, 8'hFF, 0, 1);
    rstb = 1'b1;
    send(8'h00, 0, 0, 0); expect_out("rst",   0, 8'h00, 0, 0);
    rstb = 1'b0;
    send(8'h00, 0, 0, 0); expect_out("pr0",   1, 8'h00, 0, 0);
    send(8'h33, 0, 0, 0); expect_out("pr1",   1, 8'h33, 0, 0);
    send(8'hBC, 1, 0, 0); expect_out("com8",  1, 8'hBC, 1, 1);
    send(8'h00, 0, 0, 0); expect_out("d8_0",  1, 8'hFF, 0, 1);
    send(8'h00, 0, 0, 0); expect_out("d8_1",  1, 8'h17, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
